jk_cmd_sequencer: RTL

Command-driven stimulus stage that sits directly upstream of the JK flip-flop and drives its `j`/`k` inputs. Operations (hold, reset, set, toggle) arrive on a valid/ready interface with a per-command dwell count and are buffered in a small FIFO. Each operation is then applied to the flip-flop for a programmable number of clock cycles. An optional checker compares the flip-flop's `q` feedback against an internal model after every command.

---
 rtl/jk_cmd_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command FIFO + sequencer that drives the J/K inputs of a JK flip-flop for a programmable dwell.
// Define JK_SEQ_CHECK_EN to build the q-feedback checker that raises the sticky err flag.
module jk_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [DWELL_W-1:0] cmd_dwell,
  output logic               j,
  output logic               k,
  input  logic               q,
  output logic               busy,
  output logic               done,
  output logic [7:0]         count,
  output logic               err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]        PTR_ONE = (AW+1)'(1);
  localparam logic [DWELL_W-1:0] DW_ONE  = DWELL_W'(1);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;

  state_t             state;
  logic [1:0]         op_mem [DEPTH];
  logic [DWELL_W-1:0] dw_mem [DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               full, empty, push, pop;
  logic [1:0]         head_op;
  logic [DWELL_W-1:0] head_dwell;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign pop        = !empty && ((state == IDLE) || (state == SETTLE));
  assign head_op    = op_mem[rd_ptr[AW-1:0]];
  assign head_dwell = dw_mem[rd_ptr[AW-1:0]];
  assign busy       = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr[AW-1:0]] <= cmd_op;
      dw_mem[wr_ptr[AW-1:0]] <= cmd_dwell;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // A pop from IDLE or SETTLE loads the head command and starts driving it next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      j     <= 1'b0;
      k     <= 1'b0;
      done  <= 1'b0;
      count <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, SETTLE: begin
          if (!empty) begin
            dwell_cnt <= head_dwell;
            j         <= head_op[1];
            k         <= head_op[0];
            state     <= DRIVE;
          end else begin
            j     <= 1'b0;
            k     <= 1'b0;
            state <= IDLE;
          end
        end
        DRIVE: begin
          if (dwell_cnt == '0) begin
            j     <= 1'b0;
            k     <= 1'b0;
            done  <= 1'b1;
            count <= count + 8'd1;
            state <= SETTLE;
          end else begin
            dwell_cnt <= dwell_cnt - DW_ONE;
          end
        end
        default: begin
          j     <= 1'b0;
          k     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef JK_SEQ_CHECK_EN
  logic [1:0] chk_op;
  logic       chk_dw0;
  logic       q_start;
  logic       exp_q;

  always_ff @(posedge clk) begin
    if (pop) begin
      chk_op  <= head_op;
      chk_dw0 <= head_dwell[0];
      q_start <= q;
    end
  end

  // Toggling dwell+1 times flips q only when dwell is even.
  always_comb begin
    exp_q = q_start;
    case (chk_op)
      2'b00:   exp_q = q_start;
      2'b01:   exp_q = 1'b0;
      2'b10:   exp_q = 1'b1;
      default: exp_q = q_start ^ ~chk_dw0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                  err <= 1'b0;
    else if ((state == SETTLE) && (q != exp_q)) err <= 1'b1;
  end
`else
  logic unused_q;
  assign unused_q = q;
  assign err      = 1'b0;
`endif

endmodule
